// File: rtl/sub_pkg.sv
// Shared definitions for the borrow-bypass subtractor slice.
//   - state_t : controller states (IDLE, RUN, DONE)
//   - SUB_WIDTH / SUB_SEG_W : default operand width and bits per segment
//   - n_seg() : number of segments for a given width/segment size
package sub_pkg;

    localparam int unsigned SUB_WIDTH = 32;
    localparam int unsigned SUB_SEG_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned n_seg(input int unsigned width, input int unsigned seg_w);
        return width / seg_w;
    endfunction

endpackage

// File: rtl/seg_borrow_bypass.sv
// Combinational SEG_W-bit subtract slice with borrow bypass.
// Ports:
//   a, b     : segment of minuend / subtrahend
//   bin      : borrow into the segment
//   d        : a - b - bin (modulo 2^SEG_W)
//   bout     : borrow out of the segment
//   all_prop : every bit propagates (a == b), so bout simply follows bin
module seg_borrow_bypass #(
    parameter int unsigned SEG_W = 8
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             bin,
    output logic [SEG_W-1:0] d,
    output logic             bout,
    output logic             all_prop
);

    logic gen;

    // With equal segments the incoming borrow is the only thing that can
    // underflow, so it bypasses; otherwise the segment decides on its own.
    assign all_prop = &(a ^ ~b);
    assign gen      = (a < b);
    assign bout     = all_prop ? bin : gen;
    assign d        = a - b - SEG_W'(bin);

endmodule

// File: rtl/borrow_bypass_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: Diff = A - B, one SEG_W-bit segment per
// cycle (LS segment first) through a single time-multiplexed bypass slice.
// Optional build macro: SUB_SATURATE_EN clamps Diff to signed max/min on
// signed overflow (flags Zero/Neg follow the clamped value).
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (accepted only in IDLE)
//   A, B                 : minuend, subtrahend
//   out_valid / out_ready: result handshake (held in DONE until accepted)
//   Diff                 : result
//   Bout, Zero, Neg, Ovf : unsigned borrow, zero, sign, signed overflow
module borrow_bypass_subtractor
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_WIDTH,
    parameter int unsigned SEG_W = SUB_SEG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Zero,
    output logic             Neg,
    output logic             Ovf
);

    localparam int unsigned N_SEG  = n_seg(WIDTH, SEG_W);
    localparam int unsigned SEG_CW = (N_SEG > 1) ? $clog2(N_SEG) : 1;

    state_t              state_q;
    logic [WIDTH-1:0]    a_q, b_q, diff_q;
    logic [SEG_CW-1:0]   seg_q;
    logic                borrow_q;
    logic                bout_q, zero_q, neg_q, ovf_q;

    logic [SEG_W-1:0]    seg_a, seg_b, seg_d;
    logic                seg_bout, seg_all_prop;
    logic [WIDTH-1:0]    diff_next, diff_final;
    logic                last_seg, ovf_next;

    always_comb begin
        seg_a = a_q[seg_q * SEG_W +: SEG_W];
        seg_b = b_q[seg_q * SEG_W +: SEG_W];
    end

    seg_borrow_bypass #(
        .SEG_W (SEG_W)
    ) u_seg (
        .a        (seg_a),
        .b        (seg_b),
        .bin      (borrow_q),
        .d        (seg_d),
        .bout     (seg_bout),
        .all_prop (seg_all_prop)
    );

    always_comb begin
        diff_next = diff_q;
        diff_next[seg_q * SEG_W +: SEG_W] = seg_d;
        last_seg = (seg_q == SEG_CW'(N_SEG - 1));
        ovf_next = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_next[WIDTH-1] != a_q[WIDTH-1]);
        diff_final = diff_next;
`ifdef SUB_SATURATE_EN
        // Clamp toward the sign of the minuend.
        if (ovf_next) begin
            diff_final = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            seg_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= A;
                        b_q      <= B;
                        borrow_q <= 1'b0;
                        seg_q    <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    borrow_q <= seg_bout;
                    if (last_seg) begin
                        diff_q  <= diff_final;
                        bout_q  <= seg_bout;
                        zero_q  <= (diff_final == '0);
                        neg_q   <= diff_final[WIDTH-1];
                        ovf_q   <= ovf_next;
                        seg_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        diff_q <= diff_next;
                        seg_q  <= seg_q + SEG_CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Diff      = diff_q;
    assign Bout      = bout_q;
    assign Zero      = zero_q;
    assign Neg       = neg_q;
    assign Ovf       = ovf_q;

endmodule
